imem_loader: RTL

Instruction-memory loader: the write side of the instruction-fetch path. It accepts a byte stream over a valid/ready handshake, assembles 32-bit instruction words, and writes them sequentially into instruction memory from word address 0. It holds the pipeline via `cpu_hold` until a complete image has been written, then releases it so that fetch starts from a fully loaded program.

---
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bus for imem_loader.
// master: stream producer / memory side; slave: the loader.
interface imem_loader_if #(
  parameter int unsigned ISIZE  = 32,
  parameter int unsigned AWIDTH = 8
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_wen;
  logic [AWIDTH-1:0] mem_addr;
  logic [ISIZE-1:0]  mem_wdata;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_wen,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_wen,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: takes a length-prefixed byte stream, assembles 32-bit words
// (LSB first) and writes them from word address 0, holding the CPU until the image is complete.
// Optional feature macro IMEM_LOADER_CSUM_EN: running XOR over header and data bytes, checked
// against a trailing checksum byte.
module imem_loader #(
  parameter int unsigned ISIZE  = 32,
  parameter int unsigned AWIDTH = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLenHi = 3'd1;
  localparam logic [2:0] StLenLo = 3'd2;
  localparam logic [2:0] StData  = 3'd3;
  localparam logic [2:0] StWrite = 3'd4;
`ifdef IMEM_LOADER_CSUM_EN
  localparam logic [2:0] StCsum  = 3'd5;
`endif
  localparam logic [2:0] StDone  = 3'd6;
  localparam logic [2:0] StErr   = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [ISIZE-9:0]  shift_q, shift_d;  // first three bytes of the word in flight
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [ISIZE-1:0]  wdata_q, wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic        in_ready;
  logic        accept;
  logic [15:0] len_n;
  logic [15:0] cnt_inc;

  // Handshake and status outputs are pure functions of the state.
  always_comb begin
    in_ready = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
`ifdef IMEM_LOADER_CSUM_EN
    if (state_q == StCsum) in_ready = 1'b1;
`endif
  end

  assign accept        = bus.in_valid && in_ready;
  assign len_n         = {len_q[15:8], bus.in_data};
  assign cnt_inc       = cnt_q + 16'd1;
  assign bus.in_ready  = in_ready;
  assign bus.mem_wen   = (state_q == StWrite);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign cpu_hold      = (state_q != StDone);
  assign done          = (state_q == StDone);
  assign err           = (state_q == StErr);

  // Next-state, counters and word assembly.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef IMEM_LOADER_CSUM_EN
    csum_d  = csum_q;
    if (accept && (state_q != StCsum)) csum_d = csum_q ^ bus.in_data;
`endif
    case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLenHi;
          len_d   = '0;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef IMEM_LOADER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d   = {bus.in_data, 8'h00};
          state_d = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d = len_n;
          idx_d = '0;
          if ({16'd0, len_n} > DEPTH) begin
            state_d = StErr;
          end else if (len_n == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_d = StCsum;
`else
            state_d = StDone;
`endif
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          shift_d = {bus.in_data, shift_q[ISIZE-9:8]};
          idx_d   = idx_q + 2'd1;  // wraps to 0 for the next word
          if (idx_q == 2'd3) begin
            wdata_d = {bus.in_data, shift_q};
            addr_d  = cnt_q[AWIDTH-1:0];
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        cnt_d = cnt_inc;
        if (cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_d = StCsum;
`else
          state_d = StDone;
`endif
        end else begin
          state_d = StData;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      StCsum: begin
        if (accept) state_d = (bus.in_data == csum_q) ? StDone : StErr;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef IMEM_LOADER_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

endmodule
